// File: rtl/dma_rd_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dma_rd_arb : round-robin arbiter sharing one DMA read channel between    |
// |              icache refill (req0) and waveform prefetch (req1).          |
// | Option     : define DMA_RD_TIMEOUT_EN to add an ISSUE-phase watchdog.    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module dma_rd_arb #(
  parameter int ADDR_W  = 33,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_data,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_data,
  output logic              req1_err,
  output logic              dma_rd_valid,
  output logic [ADDR_W-1:0] dma_rd_addr,
  input  logic              dma_rd_ack,
  input  logic [DATA_W-1:0] dma_rd_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0] r_state;
  logic       r_last;   // 1 when requester 1 was served most recently
  logic [1:0] w_pick;

  always_comb begin
    w_pick = 2'b00;
    if (req0_valid && req1_valid) w_pick = r_last ? 2'b01 : 2'b10;
    else if (req0_valid)          w_pick = 2'b01;
    else if (req1_valid)          w_pick = 2'b10;
  end

  assign busy = (r_state != c_IDLE);

`ifdef DMA_RD_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_expire;

  assign w_expire = (r_cnt == c_CNT_LAST);
`else
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_last       <= 1'b1;
      grant        <= 2'b00;
      dma_rd_valid <= 1'b0;
      dma_rd_addr  <= '0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      req0_data    <= '0;
      req1_data    <= '0;
`ifdef DMA_RD_TIMEOUT_EN
      r_cnt        <= '0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
`endif
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
`ifdef DMA_RD_TIMEOUT_EN
      req0_err <= 1'b0;
      req1_err <= 1'b0;
`endif
      case (r_state)
        c_IDLE: begin
          if (|w_pick) begin
            grant        <= w_pick;
            dma_rd_addr  <= w_pick[0] ? req0_addr : req1_addr;
            dma_rd_valid <= 1'b1;
            r_state      <= c_ISSUE;
`ifdef DMA_RD_TIMEOUT_EN
            r_cnt        <= '0;
`endif
          end
        end
        c_ISSUE: begin
          // A DMA ack in the expiry cycle takes priority over the timeout
          if (dma_rd_ack) begin
            dma_rd_valid <= 1'b0;
            r_state      <= c_RESP;
            req0_ack     <= grant[0];
            req1_ack     <= grant[1];
            if (grant[0]) req0_data <= dma_rd_data;
            if (grant[1]) req1_data <= dma_rd_data;
          end
`ifdef DMA_RD_TIMEOUT_EN
          else if (w_expire) begin
            dma_rd_valid <= 1'b0;
            r_state      <= c_RESP;
            req0_ack     <= grant[0];
            req1_ack     <= grant[1];
            req0_err     <= grant[0];
            req1_err     <= grant[1];
            if (grant[0]) req0_data <= '0;
            if (grant[1]) req1_data <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
`endif
        end
        c_RESP: begin
          r_last  <= grant[1];
          grant   <= 2'b00;
          r_state <= c_RELEASE;
        end
        c_RELEASE: r_state <= c_IDLE;
        default:   r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
